// File: rtl/imm_pkg.sv
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared types and constants for the immediate extension unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

    // Immediate extension mode, encoded exactly as the decode field.
    typedef enum logic [1:0] {
        IMM_ROT  = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_RSVD = 2'b11
    } imm_src_e;

    // Controller state: IDLE accepts requests, ROTATE runs the rotator.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ROTATE = 1'b1
    } imm_state_e;

    // Width of the raw instruction immediate field.
    localparam int IMM_FIELD_W = 24;

    // Width of the rotate-amount counter; holds 2*imm[11:8], i.e. 0..30.
    localparam int IMM_REM_W = 5;

endpackage : imm_pkg

`default_nettype wire

// File: rtl/imm_extend_unit_rotator.sv
// ============================================================================
//  Module      : imm_rotator
//  Description : Combinational rotate-right of DATA_W bits by 0..ROT_PER_CYCLE.
//                The carry is the MSB of the rotated value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_rotator #(
    parameter  int DATA_W        = 32,
    parameter  int ROT_PER_CYCLE = 2,
    localparam int AMT_W         = $clog2(ROT_PER_CYCLE + 1)
) (
    input  logic [DATA_W-1:0] dataIn,
    input  logic [AMT_W-1:0]  rotAmt,
    output logic [DATA_W-1:0] dataOut,
    output logic              carry
);

    // Every legal non-zero rotation, precomputed as a fixed rewiring.
    logic [DATA_W-1:0] w_cand [1:ROT_PER_CYCLE];

    for (genvar k = 1; k <= ROT_PER_CYCLE; k++) begin : g_rot
        assign w_cand[k] = {dataIn[k-1:0], dataIn[DATA_W-1:k]};
    end

    // Select the candidate matching the requested amount; zero passes through.
    always_comb begin
        dataOut = dataIn;
        for (int k = 1; k <= ROT_PER_CYCLE; k++) begin
            if (rotAmt == AMT_W'(k)) begin
                dataOut = w_cand[k];
            end
        end
    end

    assign carry = dataOut[DATA_W-1];

endmodule : imm_rotator

`default_nettype wire

// File: rtl/imm_extend_unit.sv
// ============================================================================
//  Module      : imm_extend_unit
//  Description : Extends a 24-bit instruction immediate to DATA_W bits over a
//                valid/ready handshake. Rotated imm8 (mode 00) is produced by an
//                iterative multi-cycle rotator; other modes finish in one edge.
//                Optional macro IMM_CARRY_EN adds the registered carry_out port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_unit
    import imm_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ROT_PER_CYCLE = 2,
    parameter int MEM_SIGNED    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IMM_FIELD_W-1:0] imm_value,
    input  logic [1:0]             imm_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      ext_imm,
    output logic                   imm_err,
    output logic                   busy
`ifdef IMM_CARRY_EN
    ,
    output logic                   carry_out
`endif
);

    localparam int c_AMT_W = $clog2(ROT_PER_CYCLE + 1);

    imm_state_e              r_state;
    logic [DATA_W-1:0]       r_work;
    logic [IMM_REM_W-1:0]    r_remaining;
    logic                    r_outValid;
    logic [DATA_W-1:0]       r_extImm;
    logic                    r_immErr;
`ifdef IMM_CARRY_EN
    logic                    r_carryOut;
`endif

    imm_src_e                w_src;
    logic                    w_accept;
    logic [DATA_W-1:0]       w_imm8;
    logic [IMM_REM_W-1:0]    w_rotTotal;
    logic                    w_needRot;
    logic [DATA_W-1:0]       w_directImm;
    logic                    w_directErr;
    logic [IMM_REM_W-1:0]    w_stepWide;
    logic [c_AMT_W-1:0]      w_rotAmt;
    logic [DATA_W-1:0]       w_rotated;
    logic                    w_rotCarry;

    assign w_src      = imm_src_e'(imm_src);
    assign in_ready   = (r_state == IDLE) && (!r_outValid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_imm8     = {{(DATA_W-8){1'b0}}, imm_value[7:0]};
    assign w_rotTotal = {imm_value[11:8], 1'b0};
    assign w_needRot  = (w_src == IMM_ROT) && (imm_value[11:8] != 4'd0);
    assign w_directErr = (w_src == IMM_RSVD);

    // One-edge result for every mode that needs no rotation.
    always_comb begin
        w_directImm = '0;
        case (w_src)
            IMM_ROT: w_directImm = w_imm8;
            IMM_MEM: begin
                if (MEM_SIGNED != 0) begin
                    w_directImm = {{(DATA_W-12){imm_value[11]}}, imm_value[11:0]};
                end else begin
                    w_directImm = {{(DATA_W-12){1'b0}}, imm_value[11:0]};
                end
            end
            IMM_BR:  w_directImm = {{(DATA_W-26){imm_value[23]}}, imm_value[23:0], 2'b00};
            default: w_directImm = '0;
        endcase
    end

    // Step this cycle is the smaller of the per-cycle limit and what is left.
    assign w_stepWide = (r_remaining < IMM_REM_W'(ROT_PER_CYCLE)) ? r_remaining
                                                                  : IMM_REM_W'(ROT_PER_CYCLE);
    assign w_rotAmt   = c_AMT_W'(w_stepWide);

    imm_rotator #(
        .DATA_W        (DATA_W),
        .ROT_PER_CYCLE (ROT_PER_CYCLE)
    ) u_rotator (
        .dataIn  (r_work),
        .rotAmt  (w_rotAmt),
        .dataOut (w_rotated),
        .carry   (w_rotCarry)
    );

`ifndef IMM_CARRY_EN
    logic w_unusedCarry;
    assign w_unusedCarry = w_rotCarry;
`endif

    // Controller plus output register: accept, iterate the rotation, hold/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_remaining <= '0;
            r_outValid  <= 1'b0;
            r_extImm    <= '0;
            r_immErr    <= 1'b0;
`ifdef IMM_CARRY_EN
            r_carryOut  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_outValid && out_ready) begin
                        r_outValid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_needRot) begin
                            r_work      <= w_imm8;
                            r_remaining <= w_rotTotal;
                            r_state     <= ROTATE;
                        end else begin
                            r_outValid <= 1'b1;
                            r_extImm   <= w_directImm;
                            r_immErr   <= w_directErr;
`ifdef IMM_CARRY_EN
                            r_carryOut <= 1'b0;
`endif
                        end
                    end
                end
                ROTATE: begin
                    r_work      <= w_rotated;
                    r_remaining <= r_remaining - w_stepWide;
                    if (r_remaining == w_stepWide) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b1;
                        r_extImm   <= w_rotated;
                        r_immErr   <= 1'b0;
`ifdef IMM_CARRY_EN
                        r_carryOut <= w_rotCarry;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign ext_imm   = r_extImm;
    assign imm_err   = r_immErr;
    assign busy      = (r_state == ROTATE);
`ifdef IMM_CARRY_EN
    assign carry_out = r_carryOut;
`endif

endmodule : imm_extend_unit

`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
// ============================================================================
//  Module      : tb_imm_extend_unit
//  Description : Self-checking bench for imm_extend_unit (DATA_W=32,
//                ROT_PER_CYCLE=2, MEM_SIGNED=1). Honours IMM_CARRY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_unit;

    localparam int DW  = 32;
    localparam int RPC = 2;
    localparam int MS  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] imm_value = '0;
    logic [1:0]  imm_src = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ext_imm;
    logic        imm_err;
    logic        busy;
`ifdef IMM_CARRY_EN
    logic        carry_out;
`endif

    imm_extend_unit #(
        .DATA_W        (DW),
        .ROT_PER_CYCLE (RPC),
        .MEM_SIGNED    (MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_value (imm_value),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_imm   (ext_imm),
        .imm_err   (imm_err),
        .busy      (busy)
`ifdef IMM_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;
    logic chkEn = 1'b0;

    task automatic checkW(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Result as plain arithmetic: rotate-right by r is the 64-bit product
    // v*2^(32-r) folded back onto 32 bits.
    function automatic logic [31:0] mResult(input logic [1:0] s, input logic [23:0] v);
        longint x;
        int r;
        case (s)
            2'd0: begin
                r = 2 * int'(v[11:8]);
                x = longint'(v[7:0]) * (longint'(1) << (32 - r));
                return 32'(x % (longint'(1) << 32)) | 32'(x / (longint'(1) << 32));
            end
            2'd1: begin
                x = longint'(v[11:0]);
                if (MS != 0 && v[11]) x = x - 4096;
                return 32'(x);
            end
            2'd2: begin
                x = longint'(v);
                if (v[23]) x = x - 16777216;
                return 32'(x * 4);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int mRotCycles(input logic [1:0] s, input logic [23:0] v);
        int r;
        r = 2 * int'(v[11:8]);
        if (s != 2'd0) return 0;
        return (r + RPC - 1) / RPC;
    endfunction

    function automatic logic mCarryOf(input logic [1:0] s, input logic [23:0] v);
        if (mRotCycles(s, v) == 0) return 1'b0;
        return mResult(s, v) >= 32'h8000_0000;
    endfunction

    int          mBusyLeft;
    logic        mOutValid;
    logic [31:0] mExt;
    logic        mErr;
    logic        mCarry;
    logic [31:0] mPendExt;
    logic        mPendCarry;
    logic        mInReady;

    assign mInReady = (mBusyLeft == 0) && (!mOutValid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusyLeft  <= 0;
            mOutValid  <= 1'b0;
            mExt       <= '0;
            mErr       <= 1'b0;
            mCarry     <= 1'b0;
            mPendExt   <= '0;
            mPendCarry <= 1'b0;
        end else if (mBusyLeft != 0) begin
            mBusyLeft <= mBusyLeft - 1;
            if (mBusyLeft == 1) begin
                mOutValid <= 1'b1;
                mExt      <= mPendExt;
                mErr      <= 1'b0;
                mCarry    <= mPendCarry;
            end
        end else begin
            if (mOutValid && out_ready) mOutValid <= 1'b0;
            if (in_valid && mInReady) begin
                if (mRotCycles(imm_src, imm_value) != 0) begin
                    mBusyLeft  <= mRotCycles(imm_src, imm_value);
                    mPendExt   <= mResult(imm_src, imm_value);
                    mPendCarry <= mCarryOf(imm_src, imm_value);
                end else begin
                    mOutValid <= 1'b1;
                    mExt      <= mResult(imm_src, imm_value);
                    mErr      <= (imm_src == 2'd3);
                    mCarry    <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            check1("out_valid", out_valid, mOutValid);
            check1("busy", busy, mBusyLeft != 0);
            check1("in_ready", in_ready, mInReady);
            if (mOutValid) begin
                checkW("ext_imm", ext_imm, mExt);
                check1("imm_err", imm_err, mErr);
`ifdef IMM_CARRY_EN
                check1("carry_out", carry_out, mCarry);
`endif
            end
        end
    end

    // ---------------- hand-computed literal expectations ----------------
    typedef struct {
        logic [31:0] ext;
        logic        err;
        logic        carry;
    } lit_t;
    lit_t litQ[$];

    // Each result is checked against its literal on the cycle it is popped.
    always @(negedge clk) begin : litMon
        lit_t t;
        if (chkEn && rst_n && out_valid && out_ready) begin
            if (litQ.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL lit_extra: unexpected result %h at %0t", ext_imm, $time);
            end else begin
                t = litQ.pop_front();
                checkW("lit_ext", ext_imm, t.ext);
                check1("lit_err", imm_err, t.err);
`ifdef IMM_CARRY_EN
                check1("lit_carry", carry_out, t.carry);
`endif
            end
        end
    end

    // Present a request at posedge+1 and hold it until accepted.
    task automatic doReq(input logic [1:0] s, input logic [23:0] v,
                         input logic [31:0] e, input logic er, input logic c);
        int   guard;
        logic took;
        lit_t t;
        guard     = 0;
        took      = 1'b0;
        in_valid  = 1'b1;
        imm_src   = s;
        imm_value = v;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) begin
            nCompared++;
            nMismatch++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 for imm %h", v);
        end else begin
            t.ext = e; t.err = er; t.carry = c;
            litQ.push_back(t);
        end
        in_valid  = 1'b0;
        imm_value = 24'($urandom);
        imm_src   = 2'($urandom);
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while ((out_valid || busy) && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check1("idle_timeout", out_valid || busy, 1'b0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        logic got;

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        checkW("rst_ext_imm", ext_imm, 32'h0);
        check1("rst_imm_err", imm_err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
`ifdef IMM_CARRY_EN
        check1("rst_carry", carry_out, 1'b0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chkEn = 1'b1;
        @(posedge clk);
        #1;

        // R=8 rotation: busy 4 cycles, result on the 5th edge counting accept.
        doReq(2'd0, 24'h0004FF, 32'hFF000000, 1'b0, 1'b1);
        lat = 0;
        busyCnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
            else if (busy) busyCnt++;
        end
        checkW("rot8_latency", 32'(lat), 32'd5);
        checkW("rot8_busy_cycles", 32'(busyCnt), 32'd4);
        @(posedge clk);
        #1;

        // Short rotations and carry.
        doReq(2'd0, 24'h000102, 32'h80000000, 1'b0, 1'b1);
        waitIdle();
        doReq(2'd0, 24'h000101, 32'h40000000, 1'b0, 1'b0);
        waitIdle();
        doReq(2'd0, 24'hABC2FF, 32'hF000000F, 1'b0, 1'b1);
        doReq(2'd0, 24'h000C3F, 32'h00003F00, 1'b0, 1'b0);
        doReq(2'd0, 24'h0001C3, 32'hC0000030, 1'b0, 1'b1);
        doReq(2'd0, 24'h000E81, 32'h00000810, 1'b0, 1'b0);
        waitIdle();

        // One-cycle modes back to back.
        doReq(2'd1, 24'h000800, 32'hFFFFF800, 1'b0, 1'b0);
        doReq(2'd2, 24'h800000, 32'hFE000000, 1'b0, 1'b0);
        doReq(2'd2, 24'h000001, 32'h00000004, 1'b0, 1'b0);
        doReq(2'd1, 24'h0007FF, 32'h000007FF, 1'b0, 1'b0);
        doReq(2'd1, 24'h000FFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        doReq(2'd2, 24'h7FFFFF, 32'h01FFFFFC, 1'b0, 1'b0);
        doReq(2'd0, 24'h0000AB, 32'h000000AB, 1'b0, 1'b0);
        doReq(2'd3, 24'h123456, 32'h00000000, 1'b1, 1'b0);
        doReq(2'd1, 24'h000001, 32'h00000001, 1'b0, 1'b0);
        waitIdle();

        // Backpressure, then pop and accept on the same edge.
        out_ready = 1'b0;
        doReq(2'd1, 24'h000123, 32'h00000123, 1'b0, 1'b0);
        in_valid  = 1'b1;
        imm_src   = 2'd2;
        imm_value = 24'h000010;
        begin
            lit_t t;
            t.ext = 32'h40; t.err = 1'b0; t.carry = 1'b0;
            litQ.push_back(t);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("bp_out_valid", out_valid, 1'b1);
            checkW("bp_ext_imm", ext_imm, 32'h00000123);
            check1("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check1("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check1("bp_new_valid", out_valid, 1'b1);
        checkW("bp_new_ext", ext_imm, 32'h00000040);
        @(posedge clk);
        #1;
        waitIdle();

        // Reset during the second ROTATE cycle of an R=30 rotation.
        doReq(2'd0, 24'h000F01, 32'h00000004, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        litQ.delete();
        #1;
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        checkW("mid_rst_ext_imm", ext_imm, 32'h0);
        check1("mid_rst_imm_err", imm_err, 1'b0);
`ifdef IMM_CARRY_EN
        check1("mid_rst_carry", carry_out, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check1("post_rst_out_valid", out_valid, 1'b0);
            check1("post_rst_in_ready", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        doReq(2'd1, 24'h000005, 32'h00000005, 1'b0, 1'b0);
        waitIdle();

        @(negedge clk);
        checkW("lit_leftover", 32'(litQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule : tb_imm_extend_unit

`default_nettype wire
